alu_seq_control: RTL and testbench
==================================

# alu_seq_control

Parametrised sequencer for the multi-cycle ALU: issues one-hot control strobes to the shared A/Q/M datapath for add, subtract, radix-2 Booth multiply and non-restoring divide of WIDTH-bit operands. It is the next generation of the fixed 8-bit ALU control unit. It adds:
- an internal iteration counter, so no external count flag is needed;
- divide-by-zero detection with an error flag;
- a busy/done handshake.

It sits between the top-level request interface and the datapath registers.

## Interface
- WIDTH, 8, operand width; iteration count for mul/div; legal range 2..64.
- CNT_W, $clog2(WIDTH), iteration counter width; derived, do not override.

- clk  input  1  rising-edge clock, single domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sel  input  2  00 add, 01 sub, 10 multiply, 11 divide; sampled with start, held internally.
- q_0  input  1  datapath Q[0].
- q_min1  input  1  datapath Booth bit Q[-1].
- sign  input  1  datapath A sign bit.
- div_zero  input  1  divisor register M == 0.
- c  output  13  control strobes, decoded from state.
- finish  output  1  high while in IDLE.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse on the first IDLE cycle after an operation ends.
- err  output  1  sticky divide-by-zero flag; cleared by the next accepted start or by rst.

## Operation
- States: IDLE, LD_AS, LD_MUL, LD_DIV, INIT, ADD, SUB, DSHIFT, MSHIFT, DCNT, MCNT, CORR, OUT_LO, OUT_HI, ERR.
- Encoding is one-hot internally. Any illegal or multi-hot vector goes to IDLE on the next edge.
- Strobes:
  - c[0] LD_AS, c[1] LD_MUL, c[2] LD_DIV, c[3] INIT.
  - c[4] ADD or SUB; c[5] SUB.
  - c[6] DSHIFT, c[7] MSHIFT, c[8] DCNT, c[9] MCNT, c[10] CORR, c[11] OUT_LO, c[12] OUT_HI.
  - c = 0 in IDLE and ERR.
- IDLE, start=1: go to LD_AS if sel[1]=0, LD_MUL if sel=10, LD_DIV if sel=11. Latch sel, clear err, clear counter.
- Any LD_* state goes to INIT.
- INIT:
  - add/sub: to ADD if sel[0]=0, else SUB.
  - mul: (q_0,q_min1)=10 goes to SUB, 01 goes to ADD, 00/11 go to MSHIFT.
  - div: div_zero=1 goes to ERR; otherwise sign=1 goes to ADD, else SUB.
- ADD/SUB: add/sub goes to OUT_LO; mul goes to MSHIFT; div goes to DSHIFT.
- MSHIFT goes to MCNT. DSHIFT goes to DCNT.
- MCNT/DCNT: the counter increments in these states.
  - Last iteration is cnt == WIDTH-1.
  - MCNT, last: go to OUT_LO.
  - MCNT, not last: apply the Booth decision from INIT on current q_0/q_min1.
  - DCNT, last: sign=1 goes to CORR, else OUT_LO.
  - DCNT, not last: sign=1 goes to ADD, else SUB.
- CORR goes to OUT_LO.
- OUT_LO: goes to OUT_HI for mul/div, IDLE for add/sub.
- OUT_HI goes to IDLE.
- ERR: set err, go to IDLE.
- done is registered and pulses when entering IDLE from OUT_LO, OUT_HI or ERR.
- start while busy is ignored; sel changes while busy are ignored.

## Timing
- After the rst edge: state IDLE, c=0, finish=1, busy=0, done=0, err=0, counter=0.
- rst asserted mid-operation aborts on that edge. No done pulse; err cleared.
- Latency, start-sampling edge to IDLE entry (done high in that cycle):
  - add/sub: 4 edges.
  - mul: 2 + Σ(2 or 3 per iteration) + 2 edges. With a zero multiplier this is 2·WIDTH+4, i.e. 20 for WIDTH=8.
  - div: 3·WIDTH+4 edges, +1 if CORR is taken. WIDTH=8 gives 28 or 29.
  - div by zero: 3 edges. err is high from IDLE entry.
- Booth and sign decisions use inputs as seen during MCNT/DCNT/INIT. The datapath must update on the preceding strobe edge.
- start held high continuously: a new operation starts the cycle after done, because done and IDLE coincide.

## Test plan
- Add: WIDTH=8, sel=00, 1-cycle start.
  - Required: c sequence 0x001, 0x008, 0x010, 0x800.
  - Required: done on edge 4, busy high 4 cycles, err=0.
- Multiply with zero multiplier: sel=10, q_0=q_min1=0 constant, WIDTH=8.
  - Required: exactly 8 MSHIFT/MCNT pairs, no ADD/SUB.
  - Required: OUT_LO then OUT_HI; done 20 edges after start.
- Booth decisions: sel=10, drive (q_0,q_min1) = 10, 01, 11 on successive MCNT cycles.
  - Required: SUB (c=0x030), ADD (c=0x010), direct MSHIFT respectively.
- Divide with correction: sel=11, div_zero=0, sign=1 at the final DCNT.
  - Required: CORR (c=0x400) visited, done at edge 29.
  - Rerun with sign=0: done at 28.
- Divide by zero: sel=11, div_zero=1.
  - Required: LD_DIV, INIT, ERR; done at edge 3; err=1 and c=0 in IDLE.
  - Next start: err clears on its sampling edge.
- Reset and ignore: assert rst during the 4th MCNT.
  - Required: next edge IDLE, c=0, no done.
  - start pulses while busy produce no restart.
  - Repeat with WIDTH=5: 5 iterations.

Source files
------------

// File: rtl/alu_seq_control.sv
// rtl/alu_seq_control.sv - one-hot control sequencer for the multi-cycle A/Q/M ALU
module alu_seq_control #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  sel,
  input  logic        q_0,
  input  logic        q_min1,
  input  logic        sign,
  input  logic        div_zero,
  output logic [12:0] c,
  output logic        finish,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [14:0] S_IDLE   = 15'h0001;
  localparam logic [14:0] S_LD_AS  = 15'h0002;
  localparam logic [14:0] S_LD_MUL = 15'h0004;
  localparam logic [14:0] S_LD_DIV = 15'h0008;
  localparam logic [14:0] S_INIT   = 15'h0010;
  localparam logic [14:0] S_ADD    = 15'h0020;
  localparam logic [14:0] S_SUB    = 15'h0040;
  localparam logic [14:0] S_DSHIFT = 15'h0080;
  localparam logic [14:0] S_MSHIFT = 15'h0100;
  localparam logic [14:0] S_DCNT   = 15'h0200;
  localparam logic [14:0] S_MCNT   = 15'h0400;
  localparam logic [14:0] S_CORR   = 15'h0800;
  localparam logic [14:0] S_OUT_LO = 15'h1000;
  localparam logic [14:0] S_OUT_HI = 15'h2000;
  localparam logic [14:0] S_ERR    = 15'h4000;

  logic [14:0]      state;
  logic [14:0]      state_n;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt;
  logic             is_as;
  logic             is_mul;
  logic             last;
  logic [14:0]      booth_next;

  // Operation class comes from the sel latched at start, never the live input.
  assign is_as  = ~sel_q[1];
  assign is_mul = (sel_q == 2'b10);
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  // Radix-2 Booth step: 10 subtracts M, 01 adds M, 00/11 shift straight away.
  assign booth_next = (q_0 & ~q_min1) ? S_SUB :
                      (~q_0 & q_min1) ? S_ADD : S_MSHIFT;

  // State register; reset aborts any operation on the edge it is seen.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state decode; any vector not in the item list (multi-hot, all-zero) falls to IDLE.
  always_comb begin
    state_n = S_IDLE;
    case (state)
      S_IDLE: begin
        if (!start)      state_n = S_IDLE;
        else if (!sel[1]) state_n = S_LD_AS;
        else if (sel[0])  state_n = S_LD_DIV;
        else              state_n = S_LD_MUL;
      end
      S_LD_AS, S_LD_MUL, S_LD_DIV: state_n = S_INIT;
      S_INIT: begin
        if (is_as)       state_n = sel_q[0] ? S_SUB : S_ADD;
        else if (is_mul) state_n = booth_next;
        else if (div_zero) state_n = S_ERR;
        else             state_n = sign ? S_ADD : S_SUB;
      end
      S_ADD, S_SUB: begin
        if (is_as)       state_n = S_OUT_LO;
        else if (is_mul) state_n = S_MSHIFT;
        else             state_n = S_DSHIFT;
      end
      S_MSHIFT: state_n = S_MCNT;
      S_DSHIFT: state_n = S_DCNT;
      S_MCNT:   state_n = last ? S_OUT_LO : booth_next;
      S_DCNT: begin
        if (last) state_n = sign ? S_CORR : S_OUT_LO;
        else      state_n = sign ? S_ADD : S_SUB;
      end
      S_CORR:   state_n = S_OUT_LO;
      S_OUT_LO: state_n = is_as ? S_IDLE : S_OUT_HI;
      S_OUT_HI: state_n = S_IDLE;
      S_ERR:    state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Operation context: latched sel, iteration count, done pulse and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= 2'b00;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= ((state == S_OUT_LO) || (state == S_OUT_HI) || (state == S_ERR)) &&
              (state_n == S_IDLE);
      if ((state == S_IDLE) && start) begin
        sel_q <= sel;
        cnt   <= '0;
        err   <= 1'b0;
      end else begin
        if ((state == S_MCNT) || (state == S_DCNT)) cnt <= cnt + CNT_W'(1);
        if (state == S_ERR) err <= 1'b1;
      end
    end
  end

  // Strobe decode; SUB drives the adder strobe as well as the subtract select.
  always_comb begin
    c      = '0;
    finish = (state == S_IDLE);
    busy   = (state != S_IDLE);
    case (state)
      S_LD_AS:  c[0]  = 1'b1;
      S_LD_MUL: c[1]  = 1'b1;
      S_LD_DIV: c[2]  = 1'b1;
      S_INIT:   c[3]  = 1'b1;
      S_ADD:    c[4]  = 1'b1;
      S_SUB:    c[5:4] = 2'b11;
      S_DSHIFT: c[6]  = 1'b1;
      S_MSHIFT: c[7]  = 1'b1;
      S_DCNT:   c[8]  = 1'b1;
      S_MCNT:   c[9]  = 1'b1;
      S_CORR:   c[10] = 1'b1;
      S_OUT_LO: c[11] = 1'b1;
      S_OUT_HI: c[12] = 1'b1;
      default:  c     = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_control.sv
// tb/tb_alu_seq_control.sv - randomized self-checking bench for alu_seq_control
module tb_alu_seq_control;

  localparam logic [12:0] C_NONE   = 13'h0000;
  localparam logic [12:0] C_LD_AS  = 13'h0001;
  localparam logic [12:0] C_LD_MUL = 13'h0002;
  localparam logic [12:0] C_LD_DIV = 13'h0004;
  localparam logic [12:0] C_INIT   = 13'h0008;
  localparam logic [12:0] C_ADD    = 13'h0010;
  localparam logic [12:0] C_SUB    = 13'h0030;
  localparam logic [12:0] C_DSHIFT = 13'h0040;
  localparam logic [12:0] C_MSHIFT = 13'h0080;
  localparam logic [12:0] C_DCNT   = 13'h0100;
  localparam logic [12:0] C_MCNT   = 13'h0200;
  localparam logic [12:0] C_CORR   = 13'h0400;
  localparam logic [12:0] C_OUT_LO = 13'h0800;
  localparam logic [12:0] C_OUT_HI = 13'h1000;

  logic        clk = 1'b0;
  logic        rst, start, use5;
  logic [1:0]  sel;
  logic        q_0, q_min1, sign, div_zero;
  logic        start8, start5;
  logic [12:0] c8, c5, c_o;
  logic        finish8, busy8, done8, err8;
  logic        finish5, busy5, done5, err5;
  logic        finish_o, busy_o, done_o, err_o;

  assign start8   = start & ~use5;
  assign start5   = start & use5;
  assign c_o      = use5 ? c5 : c8;
  assign finish_o = use5 ? finish5 : finish8;
  assign busy_o   = use5 ? busy5 : busy8;
  assign done_o   = use5 ? done5 : done8;
  assign err_o    = use5 ? err5 : err8;

  always #5 clk = ~clk;

  alu_seq_control #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sel(sel), .q_0(q_0), .q_min1(q_min1),
    .sign(sign), .div_zero(div_zero), .c(c8), .finish(finish8), .busy(busy8),
    .done(done8), .err(err8)
  );

  alu_seq_control #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .sel(sel), .q_0(q_0), .q_min1(q_min1),
    .sign(sign), .div_zero(div_zero), .c(c5), .finish(finish5), .busy(busy5),
    .done(done5), .err(err5)
  );

  int          vectors;
  int          miscompares;
  int          cur_w;
  logic [12:0] exp_c[$];
  logic [3:0]  exp_in[$];
  logic        exp_err;
  logic [1:0]  pairs[$];
  logic        signs[$];
  logic [16:0] obs_v[$];

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  task automatic push(input logic [12:0] cv, input logic [3:0] iv);
    exp_c.push_back(cv);
    exp_in.push_back(iv);
  endtask

  // Reference traces: list of strobe words plus the {q_0,q_min1,sign,div_zero} to present in each cycle.
  task automatic model_addsub(input logic sub);
    exp_c.delete(); exp_in.delete(); exp_err = 1'b0;
    push(C_LD_AS, rnd4());
    push(C_INIT, rnd4());
    push(sub ? C_SUB : C_ADD, rnd4());
    push(C_OUT_LO, rnd4());
  endtask

  task automatic model_mul();
    exp_c.delete(); exp_in.delete(); exp_err = 1'b0;
    push(C_LD_MUL, rnd4());
    push(C_INIT, {pairs[0], 2'($urandom)});
    for (int i = 0; i < cur_w; i++) begin
      if (pairs[i] == 2'b10)      push(C_SUB, rnd4());
      else if (pairs[i] == 2'b01) push(C_ADD, rnd4());
      push(C_MSHIFT, rnd4());
      if (i < cur_w - 1) push(C_MCNT, {pairs[i+1], 2'($urandom)});
      else               push(C_MCNT, rnd4());
    end
    push(C_OUT_LO, rnd4());
    push(C_OUT_HI, rnd4());
  endtask

  task automatic model_div(input logic zero);
    exp_c.delete(); exp_in.delete(); exp_err = 1'b0;
    push(C_LD_DIV, rnd4());
    push(C_INIT, {2'($urandom), signs[0], zero});
    if (zero) begin
      push(C_NONE, rnd4());
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < cur_w; i++) begin
      push(signs[i] ? C_ADD : C_SUB, rnd4());
      push(C_DSHIFT, rnd4());
      push(C_DCNT, {2'($urandom), signs[i+1], 1'($urandom)});
    end
    if (signs[cur_w]) push(C_CORR, rnd4());
    push(C_OUT_LO, rnd4());
    push(C_OUT_HI, rnd4());
  endtask

  task automatic rand_pairs();
    pairs.delete();
    for (int i = 0; i < cur_w; i++) pairs.push_back(2'($urandom));
  endtask

  task automatic rand_signs();
    signs.delete();
    for (int i = 0; i <= cur_w; i++) signs.push_back(1'($urandom));
  endtask

  // Expected {c, busy, done, finish, err} for observed cycle k after the start-sampling edge.
  function automatic logic [16:0] exp_vec(input int k);
    int n;
    n = exp_c.size();
    if (k < n) return {exp_c[k], 1'b1, 1'b0, 1'b0, 1'b0};
    return {13'h0000, 1'b0, (k == n), 1'b1, exp_err};
  endfunction

  function automatic int done_at();
    for (int k = 0; k < obs_v.size(); k++) if (obs_v[k][2]) return k;
    return -1;
  endfunction

  function automatic int count_c(input logic [12:0] cv);
    int n;
    n = 0;
    for (int k = 0; k < obs_v.size(); k++) if (obs_v[k][16:4] == cv) n++;
    return n;
  endfunction

  // Launch one operation, play the model's input schedule, record outputs for the trace plus two idle cycles.
  task automatic execute(input logic [1:0] op, input logic noisy);
    obs_v.delete();
    @(posedge clk); #1;
    start = 1'b1; sel = op; {q_0, q_min1, sign, div_zero} = rnd4();
    @(posedge clk);
    for (int k = 0; k < exp_c.size() + 2; k++) begin
      #1;
      if (k < exp_c.size()) begin
        {q_0, q_min1, sign, div_zero} = exp_in[k];
        start = noisy ? 1'($urandom) : 1'b0;
        sel = 2'($urandom);
      end else begin
        start = 1'b0;
        {q_0, q_min1, sign, div_zero} = rnd4();
      end
      @(negedge clk);
      obs_v.push_back({c_o, busy_o, done_o, finish_o, err_o});
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (c8 !== C_NONE) begin miscompares++; $display("FAIL reset_c got %h expected 0", c8); end
    vectors++; if (finish8 !== 1'b1) begin miscompares++; $display("FAIL reset_finish got %b expected 1", finish8); end
    vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", busy8); end
    vectors++; if (done8 !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b expected 0", done8); end
    vectors++; if (err8 !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b expected 0", err8); end
    vectors++; if ({c5, finish5, busy5, done5, err5} !== 17'h00008) begin
      miscompares++; $display("FAIL reset_w5 got %h expected 00008", {c5, finish5, busy5, done5, err5});
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_add_sub();
    logic [12:0] add_seq [4];
    logic        sub;
    add_seq = '{C_LD_AS, C_INIT, C_ADD, C_OUT_LO};
    use5 = 1'b0; cur_w = 8;
    model_addsub(1'b0);
    execute(2'b00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      vectors++; if (obs_v[k][16:4] !== add_seq[k]) begin
        miscompares++; $display("FAIL add_seq[%0d] got %h expected %h", k, obs_v[k][16:4], add_seq[k]);
      end
    end
    vectors++; if (done_at() !== 4) begin miscompares++; $display("FAIL add_latency got %0d expected 4", done_at()); end
    for (int n = 0; n < 6; n++) begin
      sub = 1'($urandom);
      model_addsub(sub);
      execute({1'b0, sub}, 1'b1);
      for (int k = 0; k < obs_v.size(); k++) begin
        vectors++; if (obs_v[k] !== exp_vec(k)) begin
          miscompares++; $display("FAIL addsub_trace run %0d cycle %0d got %h expected %h", n, k, obs_v[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_mul_zero(input logic w5);
    int iters;
    use5 = w5; cur_w = w5 ? 5 : 8; iters = cur_w;
    pairs.delete();
    repeat (cur_w) pairs.push_back(2'b00);
    model_mul();
    for (int k = 0; k < exp_in.size(); k++) exp_in[k][3:2] = 2'b00;
    execute(2'b10, 1'b0);
    for (int k = 0; k < obs_v.size(); k++) begin
      vectors++; if (obs_v[k] !== exp_vec(k)) begin
        miscompares++; $display("FAIL mulzero_trace cycle %0d got %h expected %h", k, obs_v[k], exp_vec(k));
      end
    end
    vectors++; if (count_c(C_MSHIFT) !== iters) begin
      miscompares++; $display("FAIL mulzero_shifts got %0d expected %0d", count_c(C_MSHIFT), iters);
    end
    vectors++; if (count_c(C_ADD) + count_c(C_SUB) !== 0) begin
      miscompares++; $display("FAIL mulzero_addsub got %0d expected 0", count_c(C_ADD) + count_c(C_SUB));
    end
    vectors++; if (done_at() !== 2 * iters + 4) begin
      miscompares++; $display("FAIL mulzero_latency got %0d expected %0d", done_at(), 2 * iters + 4);
    end
    vectors++; if ({obs_v[2*iters+2][16:4], obs_v[2*iters+3][16:4]} !== {C_OUT_LO, C_OUT_HI}) begin
      miscompares++; $display("FAIL mulzero_out got %h %h expected %h %h",
        obs_v[2*iters+2][16:4], obs_v[2*iters+3][16:4], C_OUT_LO, C_OUT_HI);
    end
    use5 = 1'b0; cur_w = 8;
  endtask

  task automatic test_booth();
    use5 = 1'b0; cur_w = 8;
    rand_pairs();
    pairs[0] = 2'b00; pairs[1] = 2'b10; pairs[2] = 2'b01; pairs[3] = 2'b11;
    model_mul();
    execute(2'b10, 1'b0);
    vectors++; if (obs_v[4][16:4] !== 13'h030) begin miscompares++; $display("FAIL booth_10 got %h expected 030", obs_v[4][16:4]); end
    vectors++; if (obs_v[7][16:4] !== 13'h010) begin miscompares++; $display("FAIL booth_01 got %h expected 010", obs_v[7][16:4]); end
    vectors++; if (obs_v[10][16:4] !== 13'h080) begin miscompares++; $display("FAIL booth_11 got %h expected 080", obs_v[10][16:4]); end
    for (int n = 0; n < 6; n++) begin
      rand_pairs();
      model_mul();
      execute(2'b10, 1'b1);
      for (int k = 0; k < obs_v.size(); k++) begin
        vectors++; if (obs_v[k] !== exp_vec(k)) begin
          miscompares++; $display("FAIL booth_trace run %0d cycle %0d got %h expected %h", n, k, obs_v[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_div();
    logic last_sign;
    use5 = 1'b0; cur_w = 8;
    for (int n = 0; n < 6; n++) begin
      rand_signs();
      if (n < 2) signs[cur_w] = (n == 0);
      last_sign = signs[cur_w];
      model_div(1'b0);
      execute(2'b11, (n >= 2));
      for (int k = 0; k < obs_v.size(); k++) begin
        vectors++; if (obs_v[k] !== exp_vec(k)) begin
          miscompares++; $display("FAIL div_trace run %0d cycle %0d got %h expected %h", n, k, obs_v[k], exp_vec(k));
        end
      end
      vectors++; if (done_at() !== (last_sign ? 29 : 28)) begin
        miscompares++; $display("FAIL div_latency run %0d got %0d expected %0d", n, done_at(), last_sign ? 29 : 28);
      end
      vectors++; if (count_c(C_CORR) !== int'(last_sign)) begin
        miscompares++; $display("FAIL div_corr run %0d got %0d expected %0d", n, count_c(C_CORR), last_sign);
      end
    end
  endtask

  task automatic test_div_zero();
    use5 = 1'b0; cur_w = 8;
    rand_signs();
    model_div(1'b1);
    execute(2'b11, 1'b0);
    for (int k = 0; k < obs_v.size(); k++) begin
      vectors++; if (obs_v[k] !== exp_vec(k)) begin
        miscompares++; $display("FAIL divzero_trace cycle %0d got %h expected %h", k, obs_v[k], exp_vec(k));
      end
    end
    vectors++; if (done_at() !== 3) begin miscompares++; $display("FAIL divzero_latency got %0d expected 3", done_at()); end
    vectors++; if ({obs_v[3][16:4], obs_v[3][0]} !== {C_NONE, 1'b1}) begin
      miscompares++; $display("FAIL divzero_idle c/err got %h/%b expected 0/1", obs_v[3][16:4], obs_v[3][0]);
    end
    model_addsub(1'b1);
    execute(2'b01, 1'b0);
    vectors++; if (obs_v[0][0] !== 1'b0) begin miscompares++; $display("FAIL err_clear_on_start got %b expected 0", obs_v[0][0]); end
    rand_signs();
    model_div(1'b1);
    execute(2'b11, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vectors++; if (err8 !== 1'b0) begin miscompares++; $display("FAIL err_clear_on_rst got %b expected 0", err8); end
  endtask

  task automatic test_abort(input logic w5);
    int idx, seen;
    use5 = w5; cur_w = w5 ? 5 : 8;
    rand_pairs();
    model_mul();
    idx = -1; seen = 0;
    for (int k = 0; k < exp_c.size(); k++) begin
      if (exp_c[k] == C_MCNT) begin
        seen++;
        if (seen == 4 && idx < 0) idx = k;
      end
    end
    @(posedge clk); #1;
    start = 1'b1; sel = 2'b10;
    @(posedge clk);
    for (int k = 0; k <= idx; k++) begin
      #1;
      {q_0, q_min1, sign, div_zero} = exp_in[k];
      start = 1'($urandom); sel = 2'($urandom);
      if (k == idx) rst = 1'b1;
      @(negedge clk);
      vectors++; if (c_o !== exp_c[k]) begin
        miscompares++; $display("FAIL abort_trace w%0d cycle %0d got %h expected %h", cur_w, k, c_o, exp_c[k]);
      end
      @(posedge clk);
    end
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    vectors++; if ({c_o, finish_o, busy_o, done_o, err_o} !== 17'h00008) begin
      miscompares++; $display("FAIL abort_idle w%0d got %h expected 00008", cur_w, {c_o, finish_o, busy_o, done_o, err_o});
    end
    @(negedge clk);
    vectors++; if ({done_o, finish_o} !== 2'b01) begin
      miscompares++; $display("FAIL abort_no_done w%0d got %b expected 01", cur_w, {done_o, finish_o});
    end
    use5 = 1'b0; cur_w = 8;
  endtask

  task automatic test_width5();
    logic [1:0] op;
    use5 = 1'b1; cur_w = 5;
    for (int n = 0; n < 8; n++) begin
      op = 2'($urandom);
      if (op == 2'b10) begin rand_pairs(); model_mul(); end
      else if (op == 2'b11) begin rand_signs(); model_div(1'($urandom_range(0, 3) == 0)); end
      else model_addsub(op[0]);
      execute(op, 1'b1);
      for (int k = 0; k < obs_v.size(); k++) begin
        vectors++; if (obs_v[k] !== exp_vec(k)) begin
          miscompares++; $display("FAIL w5_trace run %0d op %0d cycle %0d got %h expected %h", n, op, k, obs_v[k], exp_vec(k));
        end
      end
    end
    use5 = 1'b0; cur_w = 8;
  endtask

  task automatic test_back_to_back();
    logic [13:0] b2b [10];
    logic [13:0] got;
    b2b = '{{C_LD_AS, 1'b0}, {C_INIT, 1'b0}, {C_ADD, 1'b0}, {C_OUT_LO, 1'b0}, {C_NONE, 1'b1},
            {C_LD_AS, 1'b0}, {C_INIT, 1'b0}, {C_SUB, 1'b0}, {C_OUT_LO, 1'b0}, {C_NONE, 1'b1}};
    use5 = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; sel = 2'b00;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      #1;
      start = (k != 9);
      sel = (k >= 3) ? 2'b01 : 2'b00;
      {q_0, q_min1, sign, div_zero} = rnd4();
      @(negedge clk);
      got = {c_o, done_o};
      vectors++; if (got !== b2b[k]) begin
        miscompares++; $display("FAIL back_to_back cycle %0d got %h expected %h", k, got, b2b[k]);
      end
      @(posedge clk);
    end
    #1 start = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; start = 1'b0; sel = 2'b00; use5 = 1'b0; cur_w = 8;
    q_0 = 1'b0; q_min1 = 1'b0; sign = 1'b0; div_zero = 1'b0;
    test_reset();
    test_add_sub();
    test_mul_zero(1'b0);
    test_booth();
    test_div();
    test_div_zero();
    test_abort(1'b0);
    test_abort(1'b1);
    test_mul_zero(1'b1);
    test_width5();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
